// File: rtl/fpu_operand_unpacker.sv
// Operand unpacker for binary32: classifies the operand, splits it into fields and
// resolves the rounding mode, behind a 2-entry skid buffer with flush.
module fpu_operand_unpacker #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        valid_in,
   output logic        ready_out,
   output logic        valid_out,
   input  logic        ready_in,
   input  logic [4:0]  op_in,
   input  logic [2:0]  rm_in,
   input  logic [2:0]  frm,
   input  logic [31:0] a,
   output logic [4:0]  op,
   output logic [2:0]  rm,
   output logic        illegal_rm,
   output logic [23:0] man_a,
   output logic [7:0]  exp_a,
   output logic        sgn_a,
   output logic        zero_a,
   output logic        inf_a,
   output logic        sNaN_a,
   output logic        qNaN_a
);

   localparam int unsigned HEAD = 0;
   localparam int unsigned TAIL = 1;

   typedef struct packed {
      logic [4:0]  op;
      logic [2:0]  rm;
      logic        illegal_rm;
      logic [23:0] man;
      logic [7:0]  exp;
      logic        sgn;
      logic        zero;
      logic        inf;
      logic        snan;
      logic        qnan;
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   entry_t [DEPTH-1:0]   ent_q, ent_d;
   logic                 ready_q, ready_d;
   entry_t               dec;
   logic                 push;
   logic                 pop;

   // Full decode of the incoming operand, done once at capture time
   always_comb begin
      logic [7:0]  e;
      logic [22:0] f;
      logic [2:0]  rm_res;
      e      = a[30:23];
      f      = a[22:0];
      rm_res = (rm_in == 3'b111) ? frm : rm_in;
      dec            = '0;
      dec.op         = op_in;
      dec.rm         = rm_res;
      dec.illegal_rm = (rm_res == 3'b101) || (rm_res == 3'b110);
      dec.sgn        = a[31];
      dec.exp        = ((e == 8'h00) && (f != 23'h0)) ? 8'h01 : e;
      dec.man        = {(e != 8'h00), f};
      dec.zero       = (a[30:0] == 31'h0);
      dec.inf        = (e == 8'hff) && (f == 23'h0);
      dec.qnan       = (e == 8'hff) && f[22];
      dec.snan       = (e == 8'hff) && !f[22] && (f[21:0] != 22'h0);
   end

   assign push      = valid_in && ready_q;
   assign valid_out = (state_q != ST_EMPTY) && !flush;
   assign pop       = valid_out && ready_in;

   // Next-state and entry movement; flush wins over everything
   always_comb begin
      state_d = state_q;
      ent_d   = ent_q;
      if (flush) begin
         state_d = ST_EMPTY;
         ent_d   = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  ent_d[HEAD] = dec;
                  state_d     = ST_ONE;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  ent_d[HEAD] = dec;
               end else if (push) begin
                  ent_d[TAIL] = dec;
                  state_d     = ST_FULL;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  ent_d[HEAD] = ent_q[TAIL];
                  ent_d[TAIL] = '0;
                  state_d     = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               ent_d   = '0;
            end
         endcase
      end
      ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_EMPTY;
         ent_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ent_q   <= ent_d;
         ready_q <= ready_d;
      end
   end

   assign ready_out  = ready_q;
   assign op         = ent_q[HEAD].op;
   assign rm         = ent_q[HEAD].rm;
   assign illegal_rm = ent_q[HEAD].illegal_rm;
   assign man_a      = ent_q[HEAD].man;
   assign exp_a      = ent_q[HEAD].exp;
   assign sgn_a      = ent_q[HEAD].sgn;
   assign zero_a     = ent_q[HEAD].zero;
   assign inf_a      = ent_q[HEAD].inf;
   assign sNaN_a     = ent_q[HEAD].snan;
   assign qNaN_a     = ent_q[HEAD].qnan;

   // Structural invariants of the buffer and the classifier
   a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
      !((state_q == ST_FULL) && push));
   a_onehot_class: assert property (@(posedge clk) disable iff (!reset)
      $onehot0({zero_a, inf_a, sNaN_a, qNaN_a}));

endmodule
